// File: rtl/us_ranger_multi.sv
// -----------------------------------------------------------------------------
// us_ranger_multi
//   Round-robin ultrasonic ranger for NUM_CH sensors. Each channel gets one
//   frame of CYCLE_CLKS clocks: an idle gap, a trigger pulse, then an echo
//   measurement window. The width of the first echo pulse in the window is
//   counted (saturating). On the last frame clock the result is published:
//   pulses, the per-channel threshold bit in out, timeout, and a valid strobe.
//
// Optional build macro:
//   US_ECHO_SYNC_EN - pass every echo_rx bit through a 2-flop synchroniser
//                     (two cycles of sampling latency). When undefined, echo_rx
//                     is sampled directly and must be synchronous to clk_50M.
//
// Ports:
//   clk_50M  in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   echo_rx  in   [NUM_CH]   raw echo per channel
//   trigger  out  [NUM_CH]   sensor trigger, only the current channel pulses
//   out      out  [NUM_CH]   registered threshold result per channel
//   pulses   out  [PULSE_W]  echo width of the most recently completed frame
//   ch_idx   out  [CH_W]     channel of the current frame
//   valid    out  1          one-cycle strobe when pulses/out/timeout update
//   timeout  out  1          echo still high at frame end
//   state    out  2          0 IDLE, 1 TRIG, 2 ECHO, 3 DONE
//
// Assumes CYCLE_CLKS >= TRIG_DELAY_CLKS + TRIG_CLKS + 2 and that THRESH_CLKS
// fits in PULSE_W bits.
// -----------------------------------------------------------------------------
module us_ranger_multi #(
   parameter int NUM_CH          = 2,
   parameter int CYCLE_CLKS      = 50000,
   parameter int TRIG_DELAY_CLKS = 50,
   parameter int TRIG_CLKS       = 500,
   parameter int THRESH_CLKS     = 29410,
   parameter int PULSE_W         = 22,
   localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk_50M,
   input  logic               reset,
   input  logic [NUM_CH-1:0]  echo_rx,
   output logic [NUM_CH-1:0]  trigger,
   output logic [NUM_CH-1:0]  out,
   output logic [PULSE_W-1:0] pulses,
   output logic [CH_W-1:0]    ch_idx,
   output logic               valid,
   output logic               timeout,
   output logic [1:0]         state
);

   localparam int FC_W = (CYCLE_CLKS > 1) ? $clog2(CYCLE_CLKS) : 1;

   localparam logic [FC_W-1:0]    FC_LAST      = FC_W'(CYCLE_CLKS - 1);
   localparam logic [FC_W-1:0]    FC_ECHO_LAST = FC_W'(CYCLE_CLKS - 2);
   localparam logic [FC_W-1:0]    TRIG_START   = FC_W'(TRIG_DELAY_CLKS);
   localparam logic [FC_W-1:0]    TRIG_END     = FC_W'(TRIG_DELAY_CLKS + TRIG_CLKS);
   localparam logic [CH_W-1:0]    CH_LAST      = CH_W'(NUM_CH - 1);
   localparam logic [PULSE_W-1:0] CNT_MAX      = '1;
   localparam logic [PULSE_W-1:0] THRESH       = PULSE_W'(THRESH_CLKS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TRIG = 2'd1,
      S_ECHO = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Frame phase is a pure function of the frame counter.
   function automatic state_t phase_of(input logic [FC_W-1:0] f);
      state_t s;
      if (f == FC_LAST)       s = S_DONE;
      else if (f < TRIG_START) s = S_IDLE;
      else if (f < TRIG_END)   s = S_TRIG;
      else                     s = S_ECHO;
      return s;
   endfunction

   logic [FC_W-1:0]    fc_q, fc_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   state_t             state_q, state_d;
   logic [NUM_CH-1:0]  trigger_q, trigger_d, trig_sel;
   logic [NUM_CH-1:0]  out_q;
   logic [PULSE_W-1:0] pulses_q;
   logic               valid_q, timeout_q;
   logic [PULSE_W-1:0] count_q, count_d;
   logic               in_pulse_q, in_pulse_d;  // first pulse has started
   logic               frozen_q, frozen_d;      // first pulse has ended
   logic [NUM_CH-1:0]  echo_s;
   logic               echo_cur;
   logic               fc_last;
   logic               frame_end;

`ifdef US_ECHO_SYNC_EN
   logic [NUM_CH-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= echo_rx;
         sync2_q <= sync1_q;
      end
   end

   assign echo_s = sync2_q;
`else
   assign echo_s = echo_rx;
`endif

   assign echo_cur  = echo_s[ch_q];
   assign fc_last   = (fc_q == FC_LAST);
   // Result is captured on the edge that enters DONE, so valid and the new
   // result are visible together during the DONE cycle itself.
   assign frame_end = (state_q == S_ECHO) && (fc_q == FC_ECHO_LAST);

   // One-hot select of the channel the next cycle belongs to.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_trig_sel
      assign trig_sel[gi] = (ch_d == CH_W'(gi));
   end

   always_comb begin
      fc_d = fc_last ? '0 : fc_q + 1'b1;
      ch_d = ch_q;
      if (fc_last) begin
         ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      end
      state_d   = phase_of(fc_d);
      trigger_d = (state_d == S_TRIG) ? trig_sel : '0;

      count_d    = count_q;
      in_pulse_d = in_pulse_q;
      frozen_d   = frozen_q;
      if ((state_q == S_ECHO) && !frozen_q) begin
         if (echo_cur) begin
            count_d    = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
            in_pulse_d = 1'b1;
         end else if (in_pulse_q) begin
            frozen_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         fc_q       <= '0;
         ch_q       <= '0;
         state_q    <= S_IDLE;
         trigger_q  <= '0;
         out_q      <= '0;
         pulses_q   <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         count_q    <= '0;
         in_pulse_q <= 1'b0;
         frozen_q   <= 1'b0;
      end else begin
         fc_q      <= fc_d;
         ch_q      <= ch_d;
         state_q   <= state_d;
         trigger_q <= trigger_d;
         valid_q   <= frame_end;
         if (frame_end) begin
            pulses_q    <= count_d;
            out_q[ch_q] <= (count_d >= THRESH);
            timeout_q   <= echo_cur;
            count_q     <= '0;
            in_pulse_q  <= 1'b0;
            frozen_q    <= 1'b0;
         end else begin
            count_q    <= count_d;
            in_pulse_q <= in_pulse_d;
            frozen_q   <= frozen_d;
         end
      end
   end

   assign trigger = trigger_q;
   assign out     = out_q;
   assign pulses  = pulses_q;
   assign ch_idx  = ch_q;
   assign valid   = valid_q;
   assign timeout = timeout_q;
   assign state   = state_q;

endmodule

// File: doc/us_ranger_multi.md
US_RANGER_MULTI -- requirements
Module: us_ranger_multi

Interface
REQ-001 Parameter NUM_CH, default 2, number of ultrasonic channels serviced round-robin (1..8).
REQ-002 Parameter CYCLE_CLKS, default 50000, clocks per channel frame (1 ms at 50 MHz).
REQ-003 Parameter TRIG_DELAY_CLKS, default 50, clocks from frame start to trigger rise (1 us).
REQ-004 Parameter TRIG_CLKS, default 500, trigger high time in clocks (10 us).
REQ-005 Parameter THRESH_CLKS, default 29410, echo width at or above which out is set.
REQ-006 Parameter PULSE_W, default 22, width of the echo-width count.
REQ-007 clk_50M  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 echo_rx  input  NUM_CH  raw echo per channel, asynchronous to clk_50M.
REQ-010 trigger  output  NUM_CH  sensor trigger per channel.
REQ-011 out  output  NUM_CH  per-channel registered threshold result.
REQ-012 pulses  output  PULSE_W  echo width of the most recently completed frame.
REQ-013 ch_idx  output  $clog2(NUM_CH) (min 1)  channel of the current frame.
REQ-014 valid  output  1  one-cycle strobe; pulses/out/timeout updated this cycle.
REQ-015 timeout  output  1  echo still high at frame end for the reported channel.
REQ-016 state  output  2  FSM state: 0 IDLE, 1 TRIG, 2 ECHO, 3 DONE.

Function
REQ-017 Frame counter fc SHALL run 0..CYCLE_CLKS-1, then wrap to 0 with ch_idx advancing (NUM_CH-1 wraps to 0).
REQ-018 IDLE: fc 0..TRIG_DELAY_CLKS-1; all trigger bits low.
REQ-019 TRIG: next TRIG_CLKS cycles; only trigger[ch_idx] high.
REQ-020 ECHO: from fc=TRIG_DELAY_CLKS+TRIG_CLKS to fc=CYCLE_CLKS-2; count +1 per cycle sampled echo[ch_idx]=1.
REQ-021 Only the first high pulse in ECHO is counted; after its falling edge the count freezes until frame end.
REQ-022 Echo high during IDLE/TRIG is ignored; a pulse already high on ECHO entry is counted from entry.
REQ-023 Count saturates at 2^PULSE_W-1; no wrap.
REQ-024 DONE: fc=CYCLE_CLKS-1, one cycle: pulses<=count; out[ch_idx]<=(count>=THRESH_CLKS); timeout<=echo still high; valid=1; count cleared.
REQ-025 out bits of other channels SHALL hold their last values.
REQ-026 Echo on non-selected channels is ignored.

Reset
REQ-027 Reset low SHALL immediately clear fc, count, ch_idx, trigger, out, pulses, valid, timeout and force state IDLE.
REQ-028 Reset mid-frame discards the partial measurement; after release, the first frame starts at fc=0, channel 0.

Configuration
REQ-029 Macro US_ECHO_SYNC_EN defined: each echo_rx bit passes a 2-flop synchroniser; sampled echo lags the pin by 2 cycles; synchroniser flops reset to 0.
REQ-030 US_ECHO_SYNC_EN undefined: echo_rx sampled directly; zero added latency; the bench drives echo synchronously to clk_50M.

Verification (defaults, US_ECHO_SYNC_EN undefined)
REQ-031 Release reset -> trigger[0] high exactly fc 50..549; trigger[1] high fc 50050..50549 (absolute cycles); never both high.
REQ-032 ch0 echo high 14710 cycles from fc 600 -> at fc 49999 valid=1, pulses=14710, out[0]=0, timeout=0.
REQ-033 ch1 echo high 29410 cycles -> pulses=29410, out[1]=1; out[0] unchanged from REQ-032.
REQ-034 ch0 echo high from fc 550 to frame end -> pulses=49449, out[0]=1, timeout=1; two 1000-cycle pulses -> pulses=1000.
REQ-035 Reset asserted at fc 20000 of a ch1 frame -> all outputs 0 next edge; after release, trigger[0] rises at cycle 50.
REQ-036 With US_ECHO_SYNC_EN, repeat REQ-032 -> pulses=14710, valid timing unchanged.
